// File: rtl/stack_sequencer_pkg.sv
// Shared encodings for the operand-stack command sequencer: stack op codes,
// front-end command codes, response error codes and sequencer states.
package stack_sequencer_pkg;

  // Operations understood by the operand stack itself.
  localparam logic [1:0] STK_NONE    = 2'd0;
  localparam logic [1:0] STK_PUSH    = 2'd1;
  localparam logic [1:0] STK_POP     = 2'd2;
  localparam logic [1:0] STK_REPLACE = 2'd3;

  // Commands accepted on the request port; codes 5..7 are undefined.
  localparam logic [2:0] SEQ_PUSH  = 3'd0;
  localparam logic [2:0] SEQ_DROP  = 3'd1;
  localparam logic [2:0] SEQ_DUP   = 3'd2;
  localparam logic [2:0] SEQ_SWAP  = 3'd3;
  localparam logic [2:0] SEQ_BINOP = 3'd4;

  // Completion status reported with rsp_valid.
  localparam logic [1:0] ERR_OK        = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_BADCMD    = 2'd3;

  // Sequencer states; encodings 6 and 7 are unreachable.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP1 = 3'd1,
    S_STEP2 = 3'd2,
    S_STEP3 = 3'd3,
    S_ALU   = 3'd4,
    S_RSP   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/stack_sequencer.sv
// Command front-end for the operand stack. Expands push / drop-n / dup / swap /
// binop commands into registered one-cycle stack op pulses, keeps a mirror of
// the stack depth so illegal commands are rejected before the stack is touched,
// and hands binop operands to an external ALU.
//
// Request handshake: a command transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in S_IDLE, so exactly one
// command is in flight and req_valid seen while busy is ignored. Completion is
// a one-cycle rsp_valid pulse (S_RSP) carrying rsp_err and rsp_tos; there is
// no back-pressure on the response. alu_valid is held until alu_done arrives.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cmd,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [1:0]       rsp_err,
  output logic [WIDTH-1:0] rsp_tos,
  output logic [DEPTH:0]   depth,
  output logic             alu_valid,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_res,
  output logic [1:0]       stk_op,
  output logic [WIDTH-1:0] stk_data,
  input  logic [WIDTH-1:0] stk_tos,
  output logic [2:0]       state_dbg
);

  // Drop count (1 + req_data) is compared in a width that holds both it and depth.
  localparam int CW = ((WIDTH > DEPTH) ? WIDTH : DEPTH) + 2;
  localparam logic [DEPTH:0] CAPACITY = {1'b1, {DEPTH{1'b0}}};

  seq_state_e       state_q, state_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [1:0]       err_q, err_d;
  logic [DEPTH:0]   depth_q, depth_d;
  logic [1:0]       stk_op_q, stk_op_d;
  logic [WIDTH-1:0] stk_data_q, stk_data_d;
  logic             alu_valid_q, alu_valid_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;

  logic [CW-1:0]    drop_need;
  logic [CW-1:0]    depth_ext;

  // State and output registers; reset abandons any command without a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= SEQ_PUSH;
      a_q         <= '0;
      err_q       <= ERR_OK;
      depth_q     <= '0;
      stk_op_q    <= STK_NONE;
      stk_data_q  <= '0;
      alu_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      err_q       <= err_d;
      depth_q     <= depth_d;
      stk_op_q    <= stk_op_d;
      stk_data_q  <= stk_data_d;
      alu_valid_q <= alu_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

  // Next-state, precheck and stack-op sequencing; depth moves with each op issued.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    a_d         = a_q;
    err_d       = err_q;
    depth_d     = depth_q;
    stk_op_d    = STK_NONE;
    stk_data_d  = '0;
    alu_valid_d = alu_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    drop_need   = CW'(req_data) + CW'(1);
    depth_ext   = CW'(depth_q);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cmd_d = req_cmd;
          a_d   = stk_tos;
          err_d = ERR_OK;
          case (req_cmd)
            SEQ_PUSH: begin
              if (depth_q == CAPACITY) begin
                err_d   = ERR_OVERFLOW;
                state_d = S_RSP;
              end else begin
                stk_op_d   = STK_PUSH;
                stk_data_d = req_data;
                depth_d    = depth_q + 1'b1;
                state_d    = S_STEP1;
              end
            end
            SEQ_DUP: begin
              if (depth_q == '0) begin
                err_d   = ERR_UNDERFLOW;
                state_d = S_RSP;
              end else if (depth_q == CAPACITY) begin
                err_d   = ERR_OVERFLOW;
                state_d = S_RSP;
              end else begin
                stk_op_d   = STK_PUSH;
                stk_data_d = stk_tos;
                depth_d    = depth_q + 1'b1;
                state_d    = S_STEP1;
              end
            end
            SEQ_DROP: begin
              if (depth_ext < drop_need) begin
                err_d   = ERR_UNDERFLOW;
                state_d = S_RSP;
              end else begin
                // One POP carrying the extra count removes 1+req_data entries.
                stk_op_d   = STK_POP;
                stk_data_d = req_data;
                depth_d    = depth_q - drop_need[DEPTH:0];
                state_d    = S_STEP1;
              end
            end
            SEQ_SWAP, SEQ_BINOP: begin
              if (depth_q < (DEPTH+1)'(2)) begin
                err_d   = ERR_UNDERFLOW;
                state_d = S_RSP;
              end else begin
                stk_op_d = STK_POP;
                depth_d  = depth_q - 1'b1;
                state_d  = S_STEP1;
              end
            end
            default: begin
              err_d   = ERR_BADCMD;
              state_d = S_RSP;
            end
          endcase
        end
      end
      S_STEP1: begin
        // The POP is on the bus this cycle; the second operand appears next cycle.
        if (cmd_q == SEQ_SWAP) begin
          stk_op_d   = STK_REPLACE;
          stk_data_d = a_q;
          state_d    = S_STEP2;
        end else if (cmd_q == SEQ_BINOP) begin
          state_d = S_STEP2;
        end else begin
          state_d = S_RSP;
        end
      end
      S_STEP2: begin
        if (cmd_q == SEQ_SWAP) begin
          // stk_tos is still the old second entry (the REPLACE lands at this edge).
          stk_op_d   = STK_PUSH;
          stk_data_d = stk_tos;
          depth_d    = depth_q + 1'b1;
          state_d    = S_STEP3;
        end else begin
          alu_valid_d = 1'b1;
          alu_a_d     = stk_tos;
          alu_b_d     = a_q;
          state_d     = S_ALU;
        end
      end
      S_ALU: begin
        if (alu_done) begin
          stk_op_d    = STK_REPLACE;
          stk_data_d  = alu_res;
          alu_valid_d = 1'b0;
          state_d     = S_STEP3;
        end
      end
      S_STEP3: begin
        state_d = S_RSP;
      end
      S_RSP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_err   = rsp_valid ? err_q : ERR_OK;
  assign rsp_tos   = rsp_valid ? stk_tos : '0;
  assign depth     = depth_q;
  assign stk_op    = stk_op_q;
  assign stk_data  = stk_data_q;
  assign alu_valid = alu_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: a behavioural operand stack and ALU surround the
// DUT; a queue-based reference model predicts responses, stack ops and ALU
// operands, and independent monitors compare them as the DUT produces them.
module tb_stack_sequencer;
  import stack_sequencer_pkg::*;

  localparam int W   = 8;
  localparam int D   = 7;
  localparam int CAP = 1 << D;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_cmd;
  logic [W-1:0] req_data;
  logic         rsp_valid;
  logic [1:0]   rsp_err;
  logic [W-1:0] rsp_tos;
  logic [D:0]   depth;
  logic         alu_valid;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_done;
  logic [W-1:0] alu_res;
  logic [1:0]   stk_op;
  logic [W-1:0] stk_data;
  logic [W-1:0] stk_tos;
  logic [2:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int alu_wait_force = -1;
  bit alu_hold = 0;

  // Expected response: {latency(0 = binop, timed from alu_done), depth, tos, err}
  logic [25:0]  exp_q[$];
  // Expected stack op: {op, data}
  logic [9:0]   op_q[$];
  // Expected ALU operands: {alu_a, alu_b}
  logic [15:0]  alu_q[$];
  // Reference stack, top of stack at the back
  logic [W-1:0] ref_stk[$];

  stack_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_tos(rsp_tos), .depth(depth),
    .alu_valid(alu_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done), .alu_res(alu_res),
    .stk_op(stk_op), .stk_data(stk_data), .stk_tos(stk_tos), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural operand stack ----------------
  logic [W-1:0] mem [0:CAP-1];
  logic [D:0]   sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp <= '0;
    else begin
      case (stk_op)
        STK_PUSH: if (sp < (D+1)'(CAP)) begin mem[sp[D-1:0]] <= stk_data; sp <= sp + 1'b1; end
        STK_POP: begin
          if ({1'b0, sp} >= ({1'b0, stk_data} + 9'd1)) sp <= sp - stk_data - 1'b1;
          else sp <= '0;
        end
        STK_REPLACE: if (sp != '0) mem[D'(sp - 1'b1)] <= stk_data;
        default: ;
      endcase
    end
  end
  assign stk_tos = (sp != '0) ? mem[D'(sp - 1'b1)] : '0;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  task automatic predict(input logic [2:0] cmd, input logic [W-1:0] data);
    int n = ref_stk.size();
    logic [1:0]   err = ERR_OK;
    logic [7:0]   lat = 8'd2;
    logic [W-1:0] a, b, r, tos;
    case (cmd)
      SEQ_PUSH: begin
        if (n == CAP) err = ERR_OVERFLOW;
        else begin ref_stk.push_back(data); op_q.push_back({STK_PUSH, data}); end
      end
      SEQ_DUP: begin
        if (n == 0) err = ERR_UNDERFLOW;
        else if (n == CAP) err = ERR_OVERFLOW;
        else begin
          a = ref_stk[n-1];
          ref_stk.push_back(a);
          op_q.push_back({STK_PUSH, a});
        end
      end
      SEQ_DROP: begin
        if (int'(data) + 1 > n) err = ERR_UNDERFLOW;
        else begin
          for (int i = 0; i <= int'(data); i++) void'(ref_stk.pop_back());
          op_q.push_back({STK_POP, data});
        end
      end
      SEQ_SWAP: begin
        if (n < 2) err = ERR_UNDERFLOW;
        else begin
          a = ref_stk[n-1];
          b = ref_stk[n-2];
          ref_stk[n-1] = b;
          ref_stk[n-2] = a;
          op_q.push_back({STK_POP, 8'h00});
          op_q.push_back({STK_REPLACE, a});
          op_q.push_back({STK_PUSH, b});
          lat = 8'd4;
        end
      end
      SEQ_BINOP: begin
        if (n < 2) err = ERR_UNDERFLOW;
        else begin
          a = ref_stk.pop_back();
          b = ref_stk.pop_back();
          r = b + a;
          ref_stk.push_back(r);
          alu_q.push_back({b, a});
          op_q.push_back({STK_POP, 8'h00});
          op_q.push_back({STK_REPLACE, r});
          lat = 8'd0;
        end
      end
      default: err = ERR_BADCMD;
    endcase
    if (err != ERR_OK) lat = 8'd1;
    tos = (ref_stk.size() > 0) ? ref_stk[ref_stk.size()-1] : '0;
    exp_q.push_back({lat, 8'(ref_stk.size()), tos, err});
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [2:0] cmd, input logic [W-1:0] data);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) fail_now("req_ready_timeout");
    predict(cmd, data);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_data  = data;
    acc_cyc   = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_cmd   = 3'($urandom);
    req_data  = W'($urandom);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) fail_now("response_timeout");
  endtask

  task automatic send_random();
    int sel = $urandom_range(0, 99);
    logic [W-1:0] d = W'($urandom);
    if (sel < 35) send(SEQ_PUSH, d);
    else if (sel < 50) send(SEQ_DROP, ($urandom_range(0, 3) != 0) ? W'($urandom_range(0, 2)) : d);
    else if (sel < 65) send(SEQ_DUP, d);
    else if (sel < 80) send(SEQ_SWAP, d);
    else if (sel < 95) send(SEQ_BINOP, d);
    else send(3'($urandom_range(5, 7)), d);
  endtask

  // ---------------- response monitor ----------------
  initial begin
    logic [25:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_rsp_valid");
        else begin
          e = exp_q.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(e[1:0]));
          chk("rsp_tos", 32'(rsp_tos), 32'(e[9:2]));
          chk("depth", 32'(depth), 32'(e[17:10]));
          if (e[25:18] == 8'd0) chk("binop_done_to_rsp", 32'(cyc - done_cyc), 32'd2);
          else chk("rsp_latency", 32'(cyc - acc_cyc), 32'(e[25:18]));
        end
      end
    end
  end

  // ---------------- stack op monitor ----------------
  initial begin
    logic [9:0] o;
    forever begin
      @(negedge clk);
      if (rst_n && stk_op != STK_NONE) begin
        if (op_q.size() == 0) fail_now("unexpected_stk_op");
        else begin
          o = op_q.pop_front();
          chk("stk_op", 32'(stk_op), 32'(o[9:8]));
          chk("stk_data", 32'(stk_data), 32'(o[7:0]));
        end
      end
    end
  end

  // ---------------- ALU responder ----------------
  initial begin
    logic [15:0] x;
    int w;
    alu_done = 1'b0;
    alu_res  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && alu_valid && !alu_hold) begin
        alu_done = 1'b0;
        if (alu_q.size() == 0) fail_now("unexpected_alu_valid");
        else begin
          x = alu_q.pop_front();
          chk("alu_a", 32'(alu_a), 32'(x[15:8]));
          chk("alu_b", 32'(alu_b), 32'(x[7:0]));
        end
        w = (alu_wait_force >= 0) ? alu_wait_force : $urandom_range(0, 3);
        repeat (w) @(negedge clk);
        alu_done = 1'b1;
        alu_res  = alu_a + alu_b;
        done_cyc = cyc;
        @(negedge clk);
        alu_done = 1'b0;
        alu_res  = W'($urandom);
      end else begin
        // Stray alu_done pulses outside S_ALU must be ignored.
        alu_done = !alu_hold && ($urandom_range(0, 7) == 0);
        alu_res  = W'($urandom);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_cmd   = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    chk("reset_depth", 32'(depth), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_stk_op", 32'(stk_op), 32'(STK_NONE));
    chk("reset_alu_valid", 32'(alu_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Two pushes, then a swap of [0x11,0x22].
    send(SEQ_PUSH, 8'h11);
    send(SEQ_PUSH, 8'h22);
    send(SEQ_SWAP, 8'h00);
    wait_drain();
    chk("swap_depth", 32'(depth), 32'd2);

    // Binop on [..,0x05,0x03] with the ALU answering two cycles late.
    alu_wait_force = 2;
    send(SEQ_PUSH, 8'h05);
    send(SEQ_PUSH, 8'h03);
    send(SEQ_BINOP, 8'h00);
    wait_drain();
    alu_wait_force = -1;

    // Multi-entry drop and boundary underflow cases.
    send(SEQ_PUSH, 8'h77);
    send(SEQ_DROP, 8'd2);
    send(SEQ_DROP, 8'd1);
    send(SEQ_DROP, 8'd255);
    send(SEQ_DROP, 8'd0);
    send(SEQ_DUP, 8'h00);
    send(SEQ_SWAP, 8'h00);
    send(SEQ_BINOP, 8'h00);
    send(SEQ_DROP, 8'd0);
    send(3'd5, 8'h00);
    send(3'd7, 8'h00);
    send(SEQ_PUSH, 8'h42);
    send(SEQ_SWAP, 8'h00);
    send(SEQ_DUP, 8'h00);

    // Fill to capacity, then overflow on push and dup.
    while (ref_stk.size() < CAP) send(SEQ_PUSH, W'($urandom));
    send(SEQ_PUSH, 8'h99);
    send(SEQ_DUP, 8'h00);
    send(SEQ_SWAP, 8'h00);
    send(SEQ_DROP, 8'd200);
    wait_drain();
    chk("full_depth", 32'(depth), 32'(CAP));

    // Randomized command mix.
    for (int i = 0; i < 300; i++) send_random();
    wait_drain();

    // Reset while waiting in S_ALU abandons the command.
    send(SEQ_PUSH, 8'h0A);
    send(SEQ_PUSH, 8'h0B);
    wait_drain();
    alu_hold = 1'b1;
    send(SEQ_BINOP, 8'h00);
    guard = 0;
    while (!alu_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("alu_valid_before_reset", 32'(alu_valid), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_reset_depth", 32'(depth), 32'd0);
    chk("mid_reset_alu_valid", 32'(alu_valid), 32'd0);
    chk("mid_reset_alu_a", 32'(alu_a), 32'd0);
    chk("mid_reset_alu_b", 32'(alu_b), 32'd0);
    chk("mid_reset_stk_op", 32'(stk_op), 32'(STK_NONE));
    chk("mid_reset_stk_data", 32'(stk_data), 32'd0);
    chk("mid_reset_rsp_tos", 32'(rsp_tos), 32'd0);
    chk("mid_reset_req_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    op_q.delete();
    alu_q.delete();
    ref_stk.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    alu_hold = 1'b0;
    send(SEQ_PUSH, 8'h5A);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("post_reset_depth", 32'(depth), 32'd1);
    chk("leftover_ops", 32'(op_q.size()), 32'd0);
    chk("leftover_alu", 32'(alu_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
